// File: rtl/cell_package.sv
// Shared beat format for the ComputationCell chain, plus the stream source FSM states.
package cell_package;

  localparam int unsigned CellDataWidth  = 16;
  localparam int unsigned CellIndexWidth = 8;

  typedef struct packed {
    logic [CellDataWidth-1:0]  data;
    logic                      isValid;
    logic [CellIndexWidth-1:0] wIndex;
    logic                      isFirst;
    logic                      isLast;
    logic                      isResult;
  } cellstruct;

  typedef enum logic [1:0] {StIdle, StSend, StGap} stream_src_state_t;

  localparam cellstruct IdleBeat = '0;

  function automatic cellstruct make_beat(input logic [CellDataWidth-1:0]  data,
                                          input logic [CellIndexWidth-1:0] idx,
                                          input logic                      last);
    cellstruct b;
    b          = IdleBeat;
    b.data     = data;
    b.isValid  = 1'b1;
    b.wIndex   = idx;
    b.isFirst  = (idx == '0);
    b.isLast   = last;
    return b;
  endfunction

endpackage

// File: rtl/vector_stream_source_if.sv
// Producer-side vector handshake and the outgoing beat stream of vector_stream_source.
interface vector_stream_source_if #(
  parameter int unsigned bitwidth        = 8,
  parameter int unsigned inputVectorSize = 3
);
  import cell_package::*;

  logic [bitwidth-1:0] vecIn [inputVectorSize];
  logic                vecValid;
  logic                vecReady;
  cellstruct           streamOut;
  logic                busy;

  modport master (output vecIn, vecValid, input vecReady, streamOut, busy);
  modport slave  (input vecIn, vecValid, output vecReady, streamOut, busy);

endinterface

// File: rtl/vector_fifo.sv
// Whole-vector FIFO; the caller must never push when full or pop when empty.
module vector_fifo #(
  parameter int unsigned bitwidth        = 8,
  parameter int unsigned inputVectorSize = 3,
  parameter int unsigned bufferDepth     = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [bitwidth-1:0] push_data_i [inputVectorSize],
  input  logic                pop_i,
  output logic [bitwidth-1:0] pop_data_o [inputVectorSize],
  output logic                full_o,
  output logic                empty_o
);

  localparam int unsigned PtrW = (bufferDepth > 1) ? $clog2(bufferDepth) : 1;
  localparam int unsigned CntW = $clog2(bufferDepth + 1);

  logic [bitwidth-1:0] mem_q [bufferDepth][inputVectorSize];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(bufferDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o     = (count_q == CntW'(bufferDepth));
  assign empty_o    = (count_q == '0);
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push_i && !pop_i) begin
        count_q <= count_q + CntW'(1);
      end else if (!push_i && pop_i) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/vector_stream_source.sv
// Buffers parallel vectors and serialises each into one beat per element, with idle gaps.
module vector_stream_source
  import cell_package::*;
#(
  parameter int unsigned bitwidth        = 8,
  parameter int unsigned inputVectorSize = 3,
  parameter int unsigned gapCycles       = 2,
  parameter int unsigned bufferDepth     = 2
) (
  input logic                   clock,
  input logic                   reset,
  vector_stream_source_if.slave bus
);

  localparam int unsigned    IdxW    = (inputVectorSize > 1) ? $clog2(inputVectorSize) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(inputVectorSize - 1);
  localparam logic [3:0]      GapInit = 4'(gapCycles);

  logic                fifo_full, fifo_empty, push, pop;
  logic [bitwidth-1:0] head  [inputVectorSize];
  logic [bitwidth-1:0] vec_q [inputVectorSize];

  stream_src_state_t state_q;
  cellstruct         stream_q, first_beat, next_beat;
  logic [IdxW-1:0]   widx_q, widx_inc;
  logic [3:0]        gap_q;
  logic              at_last, gap_done;

  vector_fifo #(
    .bitwidth       (bitwidth),
    .inputVectorSize(inputVectorSize),
    .bufferDepth    (bufferDepth)
  ) u_fifo (
    .clk_i      (clock),
    .rst_i      (reset),
    .push_i     (push),
    .push_data_i(bus.vecIn),
    .pop_i      (pop),
    .pop_data_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Ready ignores a same-cycle pop: a full FIFO is never bypassed.
  assign bus.vecReady = !reset && !fifo_full;
  assign push         = bus.vecValid && bus.vecReady;

  assign at_last  = (state_q == StSend) && (widx_q == LastIdx);
  // gap_q counts the idle beats still to show, including the one on the output now.
  assign gap_done = (state_q == StGap) && (gap_q <= 4'd1);
  assign pop      = !fifo_empty && ((state_q == StIdle) || gap_done ||
                                    (at_last && (gapCycles == 0)));

  assign widx_inc   = widx_q + IdxW'(1);
  assign first_beat = make_beat(CellDataWidth'(head[0]), '0, inputVectorSize == 1);
  assign next_beat  = make_beat(CellDataWidth'(vec_q[widx_inc]), CellIndexWidth'(widx_inc),
                                widx_inc == LastIdx);

  assign bus.streamOut = reset ? IdleBeat : stream_q;
  assign bus.busy      = !reset && (!fifo_empty || (state_q != StIdle));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      stream_q <= IdleBeat;
      widx_q   <= '0;
      gap_q    <= '0;
      vec_q    <= '{default: '0};
    end else begin
      if (pop) begin
        vec_q <= head;
      end
      case (state_q)
        StIdle: begin
          if (pop) begin
            state_q  <= StSend;
            widx_q   <= '0;
            stream_q <= first_beat;
          end else begin
            stream_q <= IdleBeat;
          end
        end
        StSend: begin
          if (!at_last) begin
            widx_q   <= widx_inc;
            stream_q <= next_beat;
          end else begin
            widx_q <= '0;
            if (gapCycles != 0) begin
              state_q  <= StGap;
              gap_q    <= GapInit;
              stream_q <= IdleBeat;
            end else if (pop) begin
              stream_q <= first_beat;
            end else begin
              state_q  <= StIdle;
              stream_q <= IdleBeat;
            end
          end
        end
        StGap: begin
          if (!gap_done) begin
            gap_q    <= gap_q - 4'd1;
            stream_q <= IdleBeat;
          end else begin
            gap_q <= '0;
            if (pop) begin
              state_q  <= StSend;
              stream_q <= first_beat;
            end else begin
              state_q  <= StIdle;
              stream_q <= IdleBeat;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          stream_q <= IdleBeat;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_stream_source.sv
// Directed and random bench for vector_stream_source over three parameter sets.
module tb_vector_stream_source;
  import cell_package::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_stream_source_if #(.bitwidth(8), .inputVectorSize(3)) a_if ();
  vector_stream_source_if #(.bitwidth(8), .inputVectorSize(3)) b_if ();
  vector_stream_source_if #(.bitwidth(8), .inputVectorSize(1)) c_if ();

  vector_stream_source #(
    .bitwidth(8), .inputVectorSize(3), .gapCycles(2), .bufferDepth(2)
  ) dut_a (.clock(clk), .reset(rst), .bus(a_if));

  vector_stream_source #(
    .bitwidth(8), .inputVectorSize(3), .gapCycles(0), .bufferDepth(2)
  ) dut_b (.clock(clk), .reset(rst), .bus(b_if));

  vector_stream_source #(
    .bitwidth(8), .inputVectorSize(1), .gapCycles(2), .bufferDepth(2)
  ) dut_c (.clock(clk), .reset(rst), .bus(c_if));

  // Reference model: each accepted vector gets a start edge
  // s = max(accept + 1, previous last beat + gap + 1); beats follow on consecutive edges.
  typedef struct {
    int               s;
    logic [2:0][7:0]  e;
  } mvec_t;

  mvec_t mq[$];
  int    cur, n_cur, g_cur, d_cur;
  int    edge_n, last_end;
  int    n_assert, n_fail;

  logic      obs_ready, obs_busy;
  cellstruct obs_stream;

  always_comb begin
    case (cur)
      1: begin
        obs_ready = b_if.vecReady; obs_busy = b_if.busy; obs_stream = b_if.streamOut;
      end
      2: begin
        obs_ready = c_if.vecReady; obs_busy = c_if.busy; obs_stream = c_if.streamOut;
      end
      default: begin
        obs_ready = a_if.vecReady; obs_busy = a_if.busy; obs_stream = a_if.streamOut;
      end
    endcase
  end

  function automatic int occ();
    int c = 0;
    foreach (mq[i]) if (mq[i].s > edge_n) c++;
    return c;
  endfunction

  function automatic logic busy_exp();
    if (occ() > 0) return 1'b1;
    foreach (mq[i])
      if (mq[i].s <= edge_n && edge_n <= mq[i].s + n_cur - 1 + g_cur) return 1'b1;
    return 1'b0;
  endfunction

  function automatic cellstruct beat_exp();
    cellstruct b = '0;
    foreach (mq[i]) begin
      int k = edge_n - mq[i].s;
      if (k >= 0 && k < n_cur) begin
        b.data    = 16'(mq[i].e[k]);
        b.isValid = 1'b1;
        b.wIndex  = 8'(k);
        b.isFirst = (k == 0);
        b.isLast  = (k == n_cur - 1);
      end
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s dut=%0d edge=%0d observed=%0h expected=%0h", tag, cur, edge_n, obs, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [7:0] v0, v1, v2);
    a_if.vecValid = valid && (cur == 0);
    a_if.vecIn[0] = v0; a_if.vecIn[1] = v1; a_if.vecIn[2] = v2;
    b_if.vecValid = valid && (cur == 1);
    b_if.vecIn[0] = v0; b_if.vecIn[1] = v1; b_if.vecIn[2] = v2;
    c_if.vecValid = valid && (cur == 2);
    c_if.vecIn[0] = v0;
  endtask

  task automatic tick(input logic valid, input logic [7:0] v0, v1, v2, output logic acc);
    logic  rdy;
    mvec_t m;
    drive(valid, v0, v1, v2);
    #1;
    rdy = (occ() < d_cur);
    chk("vecReady", 64'(obs_ready), 64'(rdy));
    chk("busy", 64'(obs_busy), 64'(busy_exp()));
    @(posedge clk);
    edge_n++;
    acc = valid && rdy;
    if (acc) begin
      m.s = (edge_n + 1 > last_end + g_cur + 1) ? edge_n + 1 : last_end + g_cur + 1;
      m.e = {v2, v1, v0};
      last_end = m.s + n_cur - 1;
      mq.push_back(m);
    end
    #1;
    chk("streamOut", 64'(obs_stream), 64'(beat_exp()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    #1;
    chk("rst_vecReady", 64'(obs_ready), 64'(0));
    chk("rst_busy", 64'(obs_busy), 64'(0));
    chk("rst_streamOut", 64'(obs_stream), 64'(IdleBeat));
    @(posedge clk);
    edge_n++;
    mq.delete();
    last_end = -1000;
    #1;
    rst = 1'b0;
  endtask

  task automatic set_dut(input int d);
    cur   = d;
    n_cur = (d == 2) ? 1 : 3;
    g_cur = (d == 1) ? 0 : 2;
    d_cur = 2;
    do_reset();
  endtask

  task automatic offer(input logic [7:0] v0, v1, v2);
    logic acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) tick(1'b1, v0, v1, v2, acc);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b0, 8'd0, 8'd0, 8'd0, acc);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 80; i++) begin
      if (edge_n > last_end + g_cur + 1 && occ() == 0) break;
      tick(1'b0, 8'd0, 8'd0, 8'd0, acc);
    end
    idle(2);
  endtask

  task automatic random_run(input int n);
    logic acc;
    for (int i = 0; i < n; i++)
      tick(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), acc);
  endtask

  initial begin
    cellstruct b;
    n_assert = 0;
    n_fail   = 0;
    edge_n   = 0;
    last_end = -1000;
    cur      = 0;
    drive(1'b0, 8'd0, 8'd0, 8'd0);

    // Gap of two idle beats between consecutive vectors.
    set_dut(0);
    idle(2);
    offer(8'd4, 8'd5, 8'd6);
    offer(8'd2, 8'd3, 8'd4);
    drain();

    // Back-to-back offers while busy: the fourth waits for a free slot.
    offer(8'd1, 8'd1, 8'd1);
    offer(8'd10, 8'd11, 8'd12);
    offer(8'd20, 8'd21, 8'd22);
    offer(8'd30, 8'd31, 8'd32);
    drain();

    random_run(50);
    drain();

    // Reset while the wIndex=1 beat is on the output.
    offer(8'd4, 8'd5, 8'd6);
    for (int i = 0; i < 10; i++) begin
      b = beat_exp();
      if (b.isValid && b.wIndex == 8'd1) break;
      idle(1);
    end
    do_reset();
    idle(4);
    offer(8'd2, 8'd3, 8'd4);
    drain();

    // No gap: last beat of one vector directly followed by first of the next.
    set_dut(1);
    offer(8'd1, 8'd2, 8'd3);
    offer(8'd7, 8'd8, 8'd9);
    drain();
    random_run(50);
    drain();

    // Single-element vectors: one beat that is both first and last.
    set_dut(2);
    offer(8'd9, 8'd0, 8'd0);
    drain();
    random_run(50);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_stream_source.md
VECTOR_STREAM_SOURCE -- requirements
Module: vector_stream_source

Interface
REQ-001 SHALL have parameter bitwidth, default 8, width of each data element.
REQ-002 SHALL have parameter inputVectorSize, default 3, elements per vector (legal range 1..256).
REQ-003 SHALL have parameter gapCycles, default 2, minimum idle beats between consecutive vectors (legal range 0..15).
REQ-004 SHALL have parameter bufferDepth, default 2, number of whole vectors held in the input FIFO (legal range 1..8).
REQ-005 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port vecIn, input, bitwidth x [0:inputVectorSize-1], the parallel vector offered by the upstream producer.
REQ-008 SHALL have port vecValid, input, 1, vecIn is valid this cycle.
REQ-009 SHALL have port vecReady, output, 1, a vector is accepted on any edge where vecValid && vecReady.
REQ-010 SHALL have port streamOut, output, cellstruct, the beat stream feeding the first ComputationCell.
REQ-011 SHALL have port busy, output, 1, high while the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-012 SHALL store each accepted vector in a FIFO of bufferDepth entries; vecReady = !full, computed combinationally from the occupancy count.
REQ-013 SHALL NOT bypass the FIFO when it is full: vecReady stays low even if a pop occurs in the same cycle.
REQ-014 SHALL implement FSM states IDLE, SEND and GAP.
REQ-015 IDLE -> SEND when the FIFO is non-empty; the head vector is popped on this edge, and element 0 appears on streamOut after that edge.
REQ-016 SHALL emit SEND beats on consecutive cycles: data = vec[i], isValid=1, wIndex=i, isFirst=(i==0), isLast=(i==inputVectorSize-1), isResult=0.
REQ-017 With inputVectorSize==1, the single beat SHALL carry both isFirst=1 and isLast=1.
REQ-018 After the isLast beat: if gapCycles>0 SHALL enter GAP; otherwise SHALL enter SEND directly if the FIFO is non-empty, else IDLE.
REQ-019 GAP SHALL emit exactly gapCycles idle beats, then go to SEND if the FIFO is non-empty, else IDLE.
REQ-020 Every idle beat (IDLE or GAP) SHALL drive data=0, isValid=0, isFirst=0, isLast=0, wIndex=0, isResult=0.
REQ-021 Latency: a vector accepted on edge t with the FSM in IDLE SHALL produce its first beat after edge t+1 (one register stage through the FIFO).
REQ-022 The wIndex counter SHALL be clog2(inputVectorSize) bits wide, at least 1 bit, and SHALL clear to 0 on every isLast beat.
REQ-023 The gap counter SHALL be 4 bits and SHALL reload to gapCycles on each isLast beat.
REQ-024 A push and a pop in the same cycle SHALL leave the FIFO count unchanged, with pointers wrapping modulo bufferDepth.
REQ-025 streamOut SHALL be fully registered; no combinational path from vecIn or vecValid to streamOut.

Reset
REQ-026 Reset SHALL return the FSM to IDLE, empty the FIFO, and clear both counters.
REQ-027 During reset SHALL drive streamOut to idle-beat values and vecReady=0, busy=0.
REQ-028 Reset asserted mid-vector SHALL abort the vector with no isLast beat; the first cycle after reset SHALL be an idle beat.

Structure
REQ-029 cellstruct SHALL remain in cell_package; the FSM state enum (stream_src_state_t) SHALL be added to cell_package.
REQ-030 The FIFO SHALL be a separate sub-module named vector_fifo, parameterised by bitwidth, inputVectorSize and bufferDepth.

Verification
REQ-031 Push {4,5,6} then {2,3,4} with gapCycles=2 -> beats 4/5/6 with wIndex 0/1/2 (isFirst on 4, isLast on 6), then exactly 2 idle beats, then 2/3/4.
REQ-032 Push 3 vectors back-to-back with bufferDepth=2 while the FSM is busy -> vecReady low on the 3rd offer until the first pop; all 3 vectors are emitted in order.
REQ-033 gapCycles=0, push {1,2,3} and {7,8,9} -> six consecutive valid beats, with isLast on 3 immediately followed by isFirst on 7.
REQ-034 inputVectorSize=1, push {9} -> one beat data=9, isFirst=1, isLast=1, wIndex=0, followed by gapCycles idle beats.
REQ-035 Assert reset on the wIndex=1 beat of {4,5,6} -> no further valid beats, busy=0 after reset; a subsequent push of {2,3,4} is emitted normally.
REQ-036 Chain with cellH0..P0 (weights {0,1,2},{1,2,3},{2,3,4},{3,4,5}) -> stream matches the hand-driven sequence cycle-for-cycle, except that idle beats carry data=0 instead of X.
